// File: rtl/saida_blink_pkg.sv
// saida_blink_pkg
//   Shared definitions for the three-channel LED blink sequencer.
//   - blink_state_t : per-channel state encoding (IDLE / ON / OFF).
//     The fourth code, 2'b11, is never produced.
//     Channel logic sends it back to IDLE on the next edge.
//   - DEFAULT_HALF_CYCLES / DEFAULT_CNT_W : 0.5 s phases at a 50 MHz clock.
package saida_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10
  } blink_state_t;

  // 25e6 cycles = 0.5 s at 50 MHz; 25 bits holds 25e6-1.
  localparam int DEFAULT_HALF_CYCLES = 25_000_000;
  localparam int DEFAULT_CNT_W       = 25;

endpackage : saida_blink_pkg

// File: rtl/saida_blink_channel.sv
// saida_blink_channel
//   One blink channel: a state register, a phase counter and the output decode.
//   While i_en is high, the channel alternates HALF_CYCLES cycles ON and
//   HALF_CYCLES cycles OFF. Each enabled stretch starts with a full ON phase.
//   When i_en drops, the channel returns to IDLE and clears the counter.
//
//   Handshake: none. i_en is a level sampled on every clk edge. There is no
//   valid/ready pair, and the channel can never stall.
//
// Ports
//   clk      in  1  system clock
//   reset_n  in  1  asynchronous active-low reset
//   i_en     in  1  channel enable (one PIO bit)
//   o_led    out 1  1 while the state register holds ON
//   o_active out 1  1 while the state register holds ON or OFF
module saida_blink_channel
  import saida_blink_pkg::*;
#(
  parameter int HALF_CYCLES = DEFAULT_HALF_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_led,
  output logic o_active
);

  // Phase-end compare value, truncated to the counter width.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_CYCLES - 1);

  blink_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  blink_state_t     w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Every path other than "continue the current phase" clears the counter.
  // A disable therefore abandons the phase.
  // A re-enable always starts from cnt=0 in ON.
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (i_en) w_state_nxt = ON;
      end
      ON: begin
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = OFF;
        end else begin
          w_state_nxt = ON;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      OFF: begin
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_state_nxt = ON;
        end else begin
          w_state_nxt = OFF;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        // Unused code 2'b11: recover to IDLE.
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Decoded from the state register only, so there is no combinational path from i_en.
  assign o_led    = (r_state == ON);
  assign o_active = (r_state == ON) || (r_state == OFF);

endmodule : saida_blink_channel

// File: rtl/saida_blink_ctrl.sv
// saida_blink_ctrl
//   Three-channel LED blink sequencer driven directly by a 3-bit PIO word.
//   Each bit of cmd_in enables one independent saida_blink_channel.
//
// Ports
//   clk           in  1  system clock shared with the PIO
//   reset_n       in  1  asynchronous active-low reset
//   cmd_in        in  3  per-channel enables (PIO out_port)
//   led_out       out 3  blink outputs to the pins
//   blink_active  out 3  1 while the channel is not IDLE
module saida_blink_ctrl
  import saida_blink_pkg::*;
#(
  parameter int HALF_CYCLES = DEFAULT_HALF_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] cmd_in,
  output logic [2:0] led_out,
  output logic [2:0] blink_active
);

  for (genvar g = 0; g < 3; g++) begin : g_ch
    saida_blink_channel #(
      .HALF_CYCLES (HALF_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_en     (cmd_in[g]),
      .o_led    (led_out[g]),
      .o_active (blink_active[g])
    );
  end

endmodule : saida_blink_ctrl

// File: tb/tb_saida_blink_ctrl.sv
// tb_saida_blink_ctrl
//   Directed and randomized checks of saida_blink_ctrl.
//   dut0 is built with HALF_CYCLES=4 / CNT_W=3.
//   dut1 is built with HALF_CYCLES=1 / CNT_W=1.
//   The reference model does not copy the RTL's state machine.
//   It tracks the age of each channel's current enabled stretch, in cycles (-1 while dark).
//   The LED should be on when (age / H) is even.
module tb_saida_blink_ctrl;

  localparam int H0 = 4;
  localparam int H1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1;
  logic       rst1 = 1'b1;
  logic [2:0] cmd0 = '0;
  logic [2:0] cmd1 = '0;
  logic [2:0] led0, act0, led1, act1;

  saida_blink_ctrl #(.HALF_CYCLES(H0), .CNT_W(3)) dut0 (
    .clk (clk), .reset_n (rst0), .cmd_in (cmd0),
    .led_out (led0), .blink_active (act0)
  );

  saida_blink_ctrl #(.HALF_CYCLES(H1), .CNT_W(1)) dut1 (
    .clk (clk), .reset_n (rst1), .cmd_in (cmd1),
    .led_out (led1), .blink_active (act1)
  );

  // ---------------- reference model ----------------
  int age0 [3] = '{-1, -1, -1};
  int age1 [3] = '{-1, -1, -1};

  int checks   = 0;
  int failures = 0;

  function automatic logic [2:0] exp_led(input int a0, input int a1, input int a2, input int h);
    int a [3];
    logic [2:0] r;
    a[0] = a0; a[1] = a1; a[2] = a2;
    for (int i = 0; i < 3; i++) r[i] = (a[i] >= 0) && (((a[i] / h) % 2) == 0);
    return r;
  endfunction

  function automatic logic [2:0] exp_act(input int a0, input int a1, input int a2);
    return {a2 >= 0, a1 >= 0, a0 >= 0};
  endfunction

  // Advance both models by one clock edge.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst0 || !cmd0[i]) age0[i] = -1;
      else                   age0[i] = age0[i] + 1;
      if (!rst1 || !cmd1[i]) age1[i] = -1;
      else                   age1[i] = age1[i] + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all(input string tag);
    logic [2:0] e;
    e = exp_led(age0[0], age0[1], age0[2], H0);
    checks++;
    assert (led0 === e) else begin
      failures++;
      $error("FAIL %s dut0.led_out observed=%b expected=%b", tag, led0, e);
    end
    e = exp_act(age0[0], age0[1], age0[2]);
    checks++;
    assert (act0 === e) else begin
      failures++;
      $error("FAIL %s dut0.blink_active observed=%b expected=%b", tag, act0, e);
    end
    e = exp_led(age1[0], age1[1], age1[2], H1);
    checks++;
    assert (led1 === e) else begin
      failures++;
      $error("FAIL %s dut1.led_out observed=%b expected=%b", tag, led1, e);
    end
    e = exp_act(age1[0], age1[1], age1[2]);
    checks++;
    assert (act1 === e) else begin
      failures++;
      $error("FAIL %s dut1.blink_active observed=%b expected=%b", tag, act1, e);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a negedge. Drives the inputs, waits for the edge,
  // updates the model and checks 1 time unit later. Returns at the next negedge.
  task automatic step(input logic [2:0] c0, input logic [2:0] c1, input string tag);
    cmd0 = c0;
    cmd1 = c1;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] rc;
    int         dur;

    // Async reset assertion with all enables high.
    cmd0 = 3'b111;
    cmd1 = 3'b000;
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    check_all("reset_assert");
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(3'b111, 3'b000, "reset_hold");

    // Release mid-cycle; the next edge starts ON on all channels.
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int k = 0; k < 10; k++) step(3'b111, 3'b000, "reset_release_blink");

    // Go dark, then run a basic blink on bit 0.
    for (int k = 0; k < 2; k++) step(3'b000, 3'b000, "dark");
    for (int k = 0; k < 12; k++) step(3'b001, 3'b000, "basic_blink");
    step(3'b000, 3'b000, "basic_off");

    // Drop bit 1 mid-ON, then re-enable it for a full ON phase and beyond.
    for (int k = 0; k < 2; k++) step(3'b010, 3'b000, "drop_on");
    for (int k = 0; k < 3; k++) step(3'b000, 3'b000, "drop_gap");
    for (int k = 0; k < 6; k++) step(3'b010, 3'b000, "reenable");
    step(3'b000, 3'b000, "reenable_off");

    // Independence: bit 2 starts two cycles after bit 0.
    for (int k = 0; k < 2; k++) step(3'b001, 3'b000, "indep_a");
    for (int k = 0; k < 16; k++) step(3'b101, 3'b000, "indep_b");
    step(3'b000, 3'b000, "indep_off");

    // Single-cycle pulse.
    step(3'b001, 3'b000, "pulse_on");
    for (int k = 0; k < 2; k++) step(3'b000, 3'b000, "pulse_after");

    // HALF_CYCLES=1 on dut1: toggles every cycle.
    for (int k = 0; k < 6; k++) step(3'b000, 3'b111, "h1_toggle");
    for (int k = 0; k < 2; k++) step(3'b000, 3'b101, "h1_mixed");

    // Async reset mid-phase on both DUTs: outputs drop before the next edge.
    for (int k = 0; k < 3; k++) step(3'b111, 3'b111, "pre_async");
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      age0[i] = -1;
      age1[i] = -1;
    end
    #1;
    check_all("async_mid_cycle");
    @(negedge clk);
    step(3'b111, 3'b111, "async_hold");
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int k = 0; k < 4; k++) step(3'b111, 3'b111, "async_release");

    // Randomized enable bursts with occasional reset cycles.
    for (int b = 0; b < 30; b++) begin
      rc  = 3'($urandom_range(0, 7));
      dur = $urandom_range(1, 11);
      for (int k = 0; k < dur; k++) begin
        rst0 = ($urandom_range(0, 39) != 0);
        rst1 = ($urandom_range(0, 39) != 0);
        step(rc, 3'($urandom_range(0, 7)), "random");
      end
    end
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int k = 0; k < 2; k++) step(3'b000, 3'b000, "final_dark");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_saida_blink_ctrl
